lb2apb: RTL and testbench

- Local-bus-to-APB4 master bridge: accepts single local-bus write/read requests and performs one APB transfer per request.
- Sits between a local-bus initiator (CPU shim or a debug port) and an APB fabric of register blocks.
- Counterpart of the APB-to-local-bus bridge, with an identical local-bus handshake.
- Adds a programmable pready timeout so a dead slave cannot hang the initiator.

---
 rtl/lb2apb.sv | 138 +++++++++++++
 tb/tb_lb2apb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lb2apb.sv
// Local-bus to APB4 master bridge: one APB transfer per local-bus write/read
// request, with a programmable pready timeout so a dead slave cannot hang the initiator.
module lb2apb #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wen,
  output logic              wready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             timeout_s;

  // Next wait count and abort decision for the current ACCESS cycle.
  always_comb begin
    cnt_inc_s = cnt_r + CNT_W'(1'b1);
    if (TIMEOUT > 0) begin
      timeout_s = (cnt_inc_s == TMO_C);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Bridge FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      rdata   <= '0;
      wready  <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Writes win a tie; a held read is picked up on a later pass.
          if (wen) begin
            paddr   <= waddr;
            pwdata  <= wdata;
            pstrb   <= wstrb;
            pwrite  <= 1'b1;
            psel    <= 1'b1;
            cnt_r   <= '0;
            state_r <= SETUP;
          end else if (ren) begin
            paddr   <= raddr;
            pstrb   <= '0;
            pwrite  <= 1'b0;
            psel    <= 1'b1;
            cnt_r   <= '0;
            state_r <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (!pwrite) begin
              rdata <= prdata;
            end
            err     <= pslverr;
            wready  <= pwrite;
            rvalid  <= ~pwrite;
            state_r <= DONE;
          end else if (timeout_s) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (!pwrite) begin
              rdata <= '0;
            end
            err     <= 1'b1;
            wready  <= pwrite;
            rvalid  <= ~pwrite;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        DONE: begin
          wready  <= 1'b0;
          rvalid  <= 1'b0;
          err     <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          wready  <= 1'b0;
          rvalid  <= 1'b0;
          err     <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb2apb.sv
// Directed bench for lb2apb: a small APB slave with configurable wait states
// and a stuck-pready mode, with hand-computed expected values.
module tb_lb2apb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] waddr, raddr, paddr;
  logic [31:0] wdata, rdata, pwdata, prdata;
  logic [3:0]  wstrb, pstrb;
  logic        wen, ren, wready, rvalid, err;
  logic        psel, penable, pwrite, pready, pslverr;

  int checks   = 0;
  int failures = 0;
  int waits    = 0;
  bit stuck    = 1'b0;
  int wcnt     = 0;
  int xfers    = 0;

  lb2apb #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wen(wen), .wready(wready),
    .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Slave: answers after 'waits' ACCESS cycles unless stuck.
  assign pready = !stuck && psel && penable && (wcnt == waits);

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else if (!psel) wcnt <= 0;
    if (psel && penable && pready) xfers <= xfers + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until wready/rvalid (bounded); returns penable-high cycles seen.
  task automatic wait_done(input string tag, input int exp_cyc, output int acc);
    int cyc;
    cyc = 0;
    acc = 0;
    while (!(wready || rvalid) && cyc < 100) begin
      step();
      cyc++;
      if (penable) acc++;
    end
    check_eq(tag, cyc, exp_cyc);
  endtask

  initial begin
    int acc;
    int x0;
    bit stable;
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = 16'h0; wdata = 32'h0; wstrb = 4'h0; raddr = 16'h0;
    prdata = 32'h0; pslverr = 1'b0;
    step(); step();
    check_eq("rst_psel", psel, 1'b0);
    check_eq("rst_penable", penable, 1'b0);
    check_eq("rst_done", {wready, rvalid, err}, 3'b000);
    check_eq("rst_regs", {paddr, pstrb, rdata, pwrite}, 53'h0);
    rst = 1'b0;
    step();

    // T1: zero-wait write
    waits = 0; x0 = xfers;
    wen = 1'b1; waddr = 16'h004; wdata = 32'hdeadbeef; wstrb = 4'hF;
    step();
    check_eq("t1_setup", {psel, penable, pwrite}, 3'b101);
    check_eq("t1_paddr", paddr, 16'h004);
    check_eq("t1_pstrb", pstrb, 4'hF);
    check_eq("t1_pwdata", pwdata, 32'hdeadbeef);
    step();
    check_eq("t1_access", {psel, penable, wready}, 3'b110);
    step();
    check_eq("t1_done", {wready, rvalid, err, psel}, 4'b1000);
    wen = 1'b0;
    step();
    check_eq("t1_pulse", {wready, err}, 2'b00);
    check_eq("t1_xfers", xfers - x0, 1);

    // T2: write with 5 wait states; request fields changed mid-transfer
    waits = 5; x0 = xfers;
    wen = 1'b1; waddr = 16'h00c; wdata = 32'hcafebabe; wstrb = 4'b0110;
    step();
    waddr = 16'h000; wdata = 32'h11111111; wstrb = 4'hF;
    stable = 1'b1;
    for (int i = 2; i <= 7; i++) begin
      step();
      if (pwdata !== 32'hcafebabe || pstrb !== 4'b0110 || paddr !== 16'h00c ||
          penable !== 1'b1 || wready !== 1'b0) stable = 1'b0;
    end
    check_eq("t2_stable", stable, 1'b1);
    step();
    check_eq("t2_wready_c8", {wready, err}, 2'b10);
    wen = 1'b0;
    step();
    check_eq("t2_xfers", xfers - x0, 1);

    // T3: read with slave error
    waits = 0; prdata = 32'hc0debabe; pslverr = 1'b1;
    ren = 1'b1; raddr = 16'h014;
    step();
    check_eq("t3_setup", {psel, pwrite, pstrb}, 6'b100000);
    check_eq("t3_paddr", paddr, 16'h014);
    step(); step();
    check_eq("t3_rvalid", {rvalid, err, wready}, 3'b110);
    check_eq("t3_rdata", rdata, 32'hc0debabe);
    ren = 1'b0; pslverr = 1'b0;
    step();
    check_eq("t3_pulse", {rvalid, err}, 2'b00);
    check_eq("t3_rdata_hold", rdata, 32'hc0debabe);

    // T4: simultaneous write and read, write first
    x0 = xfers; prdata = 32'hdeadbeef;
    wen = 1'b1; waddr = 16'h010; wdata = 32'h00acce55; wstrb = 4'hF;
    ren = 1'b1; raddr = 16'h008;
    wait_done("t4_wr_lat", 3, acc);
    check_eq("t4_wr_first", {wready, rvalid, psel}, 3'b100);
    wen = 1'b0;
    step();
    wait_done("t4_rd_lat", 3, acc);
    check_eq("t4_rd", {rvalid, err, psel}, 3'b100);
    check_eq("t4_rdata", rdata, 32'hdeadbeef);
    ren = 1'b0;
    step();
    check_eq("t4_xfers", xfers - x0, 2);

    // T5: stuck slave -> timeout after 16 ACCESS cycles
    stuck = 1'b1; prdata = 32'h55555555;
    ren = 1'b1; raddr = 16'h020;
    wait_done("t5_lat", 18, acc);
    check_eq("t5_access_cycles", acc, 16);
    check_eq("t5_done", {rvalid, err, psel, penable}, 4'b1100);
    check_eq("t5_rdata", rdata, 32'h0);
    ren = 1'b0;
    step();
    stuck = 1'b0;
    wen = 1'b1; waddr = 16'h018; wdata = 32'h12345678; wstrb = 4'hF;
    wait_done("t5_wr_lat", 3, acc);
    check_eq("t5_wr", {wready, err}, 2'b10);
    wen = 1'b0;
    step();

    // T6: reset during ACCESS, then a fresh read
    waits = 5;
    ren = 1'b1; raddr = 16'h01c;
    step(); step();
    check_eq("t6_in_access", {psel, penable}, 2'b11);
    rst = 1'b1; ren = 1'b0;
    step();
    check_eq("t6_rst", {psel, penable, wready, rvalid, err}, 5'b00000);
    rst = 1'b0;
    step();
    check_eq("t6_idle", {psel, rvalid}, 2'b00);
    waits = 1; prdata = 32'ha5a5f00d;
    ren = 1'b1; raddr = 16'h01c;
    wait_done("t6_rd_lat", 4, acc);
    check_eq("t6_rd", {rvalid, err}, 2'b10);
    check_eq("t6_rdata", rdata, 32'ha5a5f00d);
    ren = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
